// File: rtl/motor_step_driver_pkg.sv
// Shared definitions for the two-axis stepper driver: axis state encoding,
// request decode, wave-drive coil table and position width.
package motor_step_driver_pkg;

  localparam int POS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_POS = 2'd1,
    ST_RUN_NEG = 2'd2,
    ST_DEAD    = 2'd3
  } axis_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_FWD  = 2'd1,
    REQ_REV  = 2'd2
  } axis_req_t;

  // Both directions at once is contradictory and is treated as no request.
  function automatic axis_req_t decode_req(input logic pos, input logic neg);
    if (pos && !neg) return REQ_FWD;
    if (!pos && neg) return REQ_REV;
    return REQ_NONE;
  endfunction

  function automatic logic [3:0] phase_to_coil(input logic [1:0] phase);
    case (phase)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

endpackage

// File: rtl/stepper_axis.sv
// One stepper axis: run/dead-time FSM, electrical phase, position count, coil register.
// Latency: state, coil and position respond one clk after a request change.
// Backpressure: none; requests are level-sampled every cycle.
module stepper_axis
  import motor_step_driver_pkg::*;
#(
  parameter int DEAD_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             req_pos,
  input  logic             req_neg,
  output logic [3:0]       coil,
  output logic [POS_W-1:0] pos,
  output logic             moving
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_TICKS);

  axis_state_t      state, state_nxt;
  axis_req_t        req;
  logic [1:0]       phase, phase_nxt;
  logic [7:0]       dead_cnt, dead_cnt_nxt;
  logic [POS_W-1:0] pos_nxt;

  assign req = decode_req(req_pos, req_neg);

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    dead_cnt_nxt = dead_cnt;
    pos_nxt      = pos;
    case (state)
      ST_IDLE: begin
        if (req == REQ_FWD)      state_nxt = ST_RUN_POS;
        else if (req == REQ_REV) state_nxt = ST_RUN_NEG;
      end
      ST_RUN_POS: begin
        if (req == REQ_NONE) state_nxt = ST_IDLE;
        else if (req == REQ_REV) begin
          state_nxt    = ST_DEAD;
          dead_cnt_nxt = DEAD_LOAD;
        end
      end
      ST_RUN_NEG: begin
        if (req == REQ_NONE) state_nxt = ST_IDLE;
        else if (req == REQ_FWD) begin
          state_nxt    = ST_DEAD;
          dead_cnt_nxt = DEAD_LOAD;
        end
      end
      ST_DEAD: begin
        if (dead_cnt == 8'd0) state_nxt = ST_IDLE;
        else if (tick)        dead_cnt_nxt = dead_cnt - 8'd1;
      end
    endcase

    // Steps only while staying in a run state, so the entry tick never steps.
    if (tick && state == ST_RUN_POS && state_nxt == ST_RUN_POS) begin
      phase_nxt = phase + 2'd1;
      pos_nxt   = pos + POS_W'(1);
    end else if (tick && state == ST_RUN_NEG && state_nxt == ST_RUN_NEG) begin
      phase_nxt = phase - 2'd1;
      pos_nxt   = pos - POS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      phase    <= 2'd0;
      dead_cnt <= 8'd0;
      pos      <= '0;
      coil     <= 4'b0000;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      dead_cnt <= dead_cnt_nxt;
      pos      <= pos_nxt;
      coil     <= (state_nxt == ST_RUN_POS || state_nxt == ST_RUN_NEG) ?
                  phase_to_coil(phase_nxt) : 4'b0000;
    end
  end

  assign moving = (state == ST_RUN_POS) || (state == ST_RUN_NEG);

endmodule

// File: rtl/motor_step_driver.sv
// Two-axis (theta/phi) wave-drive stepper driver with a shared step-rate prescaler.
// Latency: one clk from request change to outputs; steps land on prescaler ticks.
// Backpressure: none; move requests are level inputs.
module motor_step_driver
  import motor_step_driver_pkg::*;
#(
  parameter int STEP_DIV   = 50000,
  parameter int DEAD_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_out_theta_pos,
  input  logic             s_out_theta_neg,
  input  logic             s_out_phi_pos,
  input  logic             s_out_phi_neg,
  output logic [3:0]       coil_theta,
  output logic [3:0]       coil_phi,
  output logic [POS_W-1:0] pos_theta,
  output logic [POS_W-1:0] pos_phi,
  output logic             moving_theta,
  output logic             moving_phi
);

  localparam int            PW       = $clog2(STEP_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  stepper_axis #(.DEAD_TICKS(DEAD_TICKS)) u_theta (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .req_pos (s_out_theta_pos),
    .req_neg (s_out_theta_neg),
    .coil    (coil_theta),
    .pos     (pos_theta),
    .moving  (moving_theta)
  );

  stepper_axis #(.DEAD_TICKS(DEAD_TICKS)) u_phi (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .req_pos (s_out_phi_pos),
    .req_neg (s_out_phi_neg),
    .coil    (coil_phi),
    .pos     (pos_phi),
    .moving  (moving_phi)
  );

endmodule

// File: tb/tb_motor_step_driver.sv
// Bench for motor_step_driver: main instance at STEP_DIV=4/DEAD_TICKS=2, plus a
// STEP_DIV=2 instance used only to reach the 0x7FFF -> 0x8000 position boundary.
module tb_motor_step_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic tp = 1'b0, tn = 1'b0, pp = 1'b0, pn = 1'b0;
  logic [3:0]  coil_theta, coil_phi;
  logic [15:0] pos_theta, pos_phi;
  logic        moving_theta, moving_phi;

  logic rst_w = 1'b1;
  logic pp_w = 1'b0;
  logic [3:0]  coil_theta_w, coil_phi_w;
  logic [15:0] pos_theta_w, pos_phi_w;
  logic        moving_theta_w, moving_phi_w;

  motor_step_driver #(.STEP_DIV(4), .DEAD_TICKS(2)) dut (
    .clk(clk), .rst(rst),
    .s_out_theta_pos(tp), .s_out_theta_neg(tn),
    .s_out_phi_pos(pp), .s_out_phi_neg(pn),
    .coil_theta(coil_theta), .coil_phi(coil_phi),
    .pos_theta(pos_theta), .pos_phi(pos_phi),
    .moving_theta(moving_theta), .moving_phi(moving_phi)
  );

  motor_step_driver #(.STEP_DIV(2), .DEAD_TICKS(2)) dut_w (
    .clk(clk), .rst(rst_w),
    .s_out_theta_pos(1'b0), .s_out_theta_neg(1'b0),
    .s_out_phi_pos(pp_w), .s_out_phi_neg(1'b0),
    .coil_theta(coil_theta_w), .coil_phi(coil_phi_w),
    .pos_theta(pos_theta_w), .pos_phi(pos_phi_w),
    .moving_theta(moving_theta_w), .moving_phi(moving_phi_w)
  );

  typedef struct packed {
    logic [3:0]  ct;
    logic [15:0] pt;
    logic        mt;
    logic [3:0]  cp;
    logic [15:0] pp;
    logic        mp;
  } exp_t;

  typedef struct {
    logic tp, tn, pp, pn;
    int   n;
    exp_t e;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passed = 0;

  function automatic exp_t mk(input logic [3:0] ct, input logic [15:0] pt, input logic mt,
                              input logic [3:0] cp, input logic [15:0] ppos, input logic mp);
    return {ct, pt, mt, cp, ppos, mp};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input logic a, input logic b, input logic c, input logic d);
    tp = a; tn = b; pp = c; pn = d;
  endtask

  task automatic push_exp(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_pop(input bit wide);
    exp_t  got, want;
    string nm;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    want = exp_q.pop_front();
    nm   = name_q.pop_front();
    if (wide) got = {coil_theta_w, pos_theta_w, moving_theta_w, coil_phi_w, pos_phi_w, moving_phi_w};
    else      got = {coil_theta, pos_theta, moving_theta, coil_phi, pos_phi, moving_phi};
    if (got !== want)
      $display("FAIL %s: got ct=%b pt=%h mt=%b cp=%b pp=%h mp=%b, required ct=%b pt=%h mt=%b cp=%b pp=%h mp=%b",
               nm, got.ct, got.pt, got.mt, got.cp, got.pp, got.mp,
               want.ct, want.pt, want.mt, want.cp, want.pp, want.mp);
    else
      passed++;
  endtask

  vec_t vecs[14];

  initial begin
    // Inputs are applied right after an edge; cycle 0 is the release point,
    // so prescaler ticks land on edges 4, 8, 12, ...
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1, mk(4'b0001, 16'd0, 1'b1, 4'b0000, 16'h0000, 1'b0)};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3, mk(4'b0010, 16'd1, 1'b1, 4'b0000, 16'h0000, 1'b0)};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4, mk(4'b0100, 16'd2, 1'b1, 4'b0000, 16'h0000, 1'b0)};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4, mk(4'b1000, 16'd3, 1'b1, 4'b0000, 16'h0000, 1'b0)};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4, mk(4'b0001, 16'd4, 1'b1, 4'b0000, 16'h0000, 1'b0)};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4, mk(4'b0010, 16'd5, 1'b1, 4'b0000, 16'h0000, 1'b0)};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, mk(4'b0000, 16'd5, 1'b0, 4'b0000, 16'h0000, 1'b0)};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7, mk(4'b0000, 16'd5, 1'b0, 4'b0000, 16'h0000, 1'b0)};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, mk(4'b0000, 16'd5, 1'b0, 4'b0000, 16'h0000, 1'b0)};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, mk(4'b0010, 16'd5, 1'b1, 4'b0001, 16'h0000, 1'b1)};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2, mk(4'b0001, 16'd4, 1'b1, 4'b1000, 16'hFFFF, 1'b1)};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, mk(4'b0000, 16'd4, 1'b0, 4'b0000, 16'hFFFF, 1'b0)};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, mk(4'b0001, 16'd4, 1'b1, 4'b1000, 16'hFFFF, 1'b1)};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 2, mk(4'b0010, 16'd5, 1'b1, 4'b0001, 16'h0000, 1'b1)};

    // Reset state, asynchronous and then held across clock edges.
    #1 rst = 1'b0; rst_w = 1'b0;
    #1;
    push_exp("reset_async", mk(4'b0000, 16'd0, 1'b0, 4'b0000, 16'd0, 1'b0));
    check_pop(1'b0);
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset_held", mk(4'b0000, 16'd0, 1'b0, 4'b0000, 16'd0, 1'b0));
    check_pop(1'b0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      set_req(vecs[i].tp, vecs[i].tn, vecs[i].pp, vecs[i].pn);
      push_exp($sformatf("vec%0d", i), vecs[i].e);
      cyc(vecs[i].n);
      check_pop(1'b0);
    end

    // Request raised in the tick cycle: no step on that tick, one on the next.
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("tick_align_idle", mk(4'b0000, 16'd5, 1'b0, 4'b0000, 16'h0000, 1'b0));
    cyc(3);
    check_pop(1'b0);
    set_req(1'b1, 1'b0, 1'b0, 0);
    push_exp("tick_entry_nostep", mk(4'b0010, 16'd5, 1'b1, 4'b0000, 16'h0000, 1'b0));
    cyc(1);
    check_pop(1'b0);
    push_exp("tick_entry_wait", mk(4'b0010, 16'd5, 1'b1, 4'b0000, 16'h0000, 1'b0));
    cyc(3);
    check_pop(1'b0);
    push_exp("tick_first_step", mk(4'b0100, 16'd6, 1'b1, 4'b0000, 16'h0000, 1'b0));
    cyc(1);
    check_pop(1'b0);
    push_exp("tick_one_step_only", mk(4'b0100, 16'd6, 1'b1, 4'b0000, 16'h0000, 1'b0));
    cyc(3);
    check_pop(1'b0);

    // Reset pulse between edges while phi runs negative.
    set_req(1'b0, 1'b0, 1'b0, 1'b1);
    push_exp("phi_run_neg", mk(4'b0000, 16'd6, 1'b0, 4'b0001, 16'h0000, 1'b1));
    cyc(1);
    check_pop(1'b0);
    cyc(2);
    #2 rst = 1'b0;
    #1;
    push_exp("reset_midrun", mk(4'b0000, 16'd0, 1'b0, 4'b0000, 16'h0000, 1'b0));
    check_pop(1'b0);
    #2 rst = 1'b1;
    push_exp("post_reset_entry", mk(4'b0000, 16'd0, 1'b0, 4'b0001, 16'h0000, 1'b1));
    cyc(3);
    check_pop(1'b0);
    push_exp("post_reset_first_tick", mk(4'b0000, 16'd0, 1'b0, 4'b1000, 16'hFFFF, 1'b1));
    cyc(1);
    check_pop(1'b0);
    set_req(1'b0, 1'b0, 1'b0, 1'b0);

    // Fast instance: one step every 2 cycles, step k lands on edge 2k.
    rst_w = 1'b1;
    pp_w  = 1'b1;
    push_exp("wrap_7fff", mk(4'b0000, 16'd0, 1'b0, 4'b1000, 16'h7FFF, 1'b1));
    cyc(65534);
    check_pop(1'b1);
    push_exp("wrap_8000", mk(4'b0000, 16'd0, 1'b0, 4'b0001, 16'h8000, 1'b1));
    cyc(2);
    check_pop(1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
